load_store_request_queue: RTL and testbench
===========================================

LOAD_STORE_REQUEST_QUEUE -- requirements
Module: load_store_request_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: request FIFO entries; power of two, >= 2.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: store value and result width.
REQ-004 SHALL have parameter CMD_WIDTH, default 4: opaque command/type/atomic bundle width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 req_valid  in  1  execute stage offers a request.
REQ-009 req_ready  out  1  queue accepts the request this cycle.
REQ-010 req_addr / req_cmd / req_store_value  in  ADDR_WIDTH / CMD_WIDTH / DATA_WIDTH  request payload.
REQ-011 flush  in  1  discard all pending work (pipeline kill).
REQ-012 lsu_enable  out  1  level request to load-store unit.
REQ-013 lsu_addr / lsu_cmd / lsu_store_value  out  as req_*  payload of the FIFO head.
REQ-014 lsu_done / lsu_fault  in  1 / 1  single-cycle completion pulse / fault qualifier.
REQ-015 lsu_result  in  DATA_WIDTH  valid when lsu_done=1.
REQ-016 resp_valid / resp_ready  out / in  1 / 1  response handshake.
REQ-017 resp_result / resp_fault  out  DATA_WIDTH / 1  registered response.
REQ-018 count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 FIFO SHALL use rd/wr pointers with one extra wrap bit; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-020 req_ready SHALL be 1 iff count < DEPTH, flush=0, state != DRAIN, and no faulted response is held; no same-cycle bypass when full.
REQ-021 Push (req_valid & req_ready) and pop in the same cycle SHALL both take effect; count stays unchanged.
REQ-022 FSM states: IDLE, BUSY, RESP, DRAIN.
REQ-023 IDLE -> BUSY when FIFO non-empty; an entry pushed in cycle N SHALL raise lsu_enable no earlier than N+1.
REQ-024 BUSY: lsu_enable=1 with head payload held stable; on lsu_done, capture lsu_result/lsu_fault, pop head, -> RESP.
REQ-025 RESP: resp_valid=1, payload stable until resp_ready; on handshake -> BUSY if FIFO non-empty else IDLE.
REQ-026 Faulted-response handshake (resp_fault=1) SHALL discard all remaining FIFO entries and -> IDLE.
REQ-027 flush in IDLE/RESP SHALL empty the FIFO, drop any held response (resp_valid=0 next cycle), -> IDLE.
REQ-028 flush in BUSY SHALL empty the FIFO and -> DRAIN, keeping lsu_enable=1 until lsu_done; result discarded, then -> IDLE.
REQ-029 flush in the same cycle as lsu_done in BUSY SHALL discard the result and -> IDLE directly.
REQ-030 lsu_done outside BUSY/DRAIN SHALL be ignored.

Reset
REQ-031 On rst: state=IDLE, pointers=0, count=0, lsu_enable=0, resp_valid=0, resp_fault=0, resp_result=0; req_ready=1 in the first cycle after release.
REQ-032 rst asserted mid-operation SHALL abandon any outstanding LSU access immediately; no response produced.

Verification
REQ-033 Push A=0x100 load, lsu_done 3 cycles later with result 0xDEADBEEF -> resp_valid one cycle after done, resp_result=0xDEADBEEF, resp_fault=0.
REQ-034 Push 4 requests back-to-back with DEPTH=4, LSU stalled -> count=4, req_ready=0; completions return in push order.
REQ-035 Second of 3 queued requests faults -> resp_fault=1; after handshake count=0, third never issued (lsu_enable stays 0).
REQ-036 flush in BUSY with 2 queued -> count=0 next cycle, lsu_enable held until lsu_done, no resp_valid, IDLE afterwards.
REQ-037 resp_ready=0 for 5 cycles during RESP -> resp payload stable, lsu_enable=0, pushes still accepted until full.
REQ-038 rst asserted while BUSY -> all outputs at reset values asynchronously, count=0.

Source files
------------

// File: rtl/load_store_request_queue.sv
// -----------------------------------------------------------------------------
// load_store_request_queue
//
// Buffers load/store requests from the execute stage in a small FIFO and hands
// them one at a time to the load-store unit (LSU). Each LSU completion is
// turned into a registered response that is held until the consumer takes it.
// A faulted response, once accepted, kills all younger queued requests. A
// pipeline flush empties the queue; an LSU access already in flight is allowed
// to finish (DRAIN) and its result is thrown away.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid / req_ready     request handshake from execute stage
//   req_addr/cmd/store_value  request payload
//   flush                     discard all pending work
//   lsu_enable                level request to LSU (head entry)
//   lsu_addr/cmd/store_value  payload of the FIFO head
//   lsu_done / lsu_fault      single-cycle completion pulse / fault qualifier
//   lsu_result                LSU return data, valid with lsu_done
//   resp_valid / resp_ready   response handshake
//   resp_result / resp_fault  registered response payload
//   count                     current FIFO occupancy
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no LSU access, no response held; waits for a queued entry
//   BUSY   | head entry presented to LSU, waiting for lsu_done
//   RESP   | response held on resp_*, waiting for resp_ready
//   DRAIN  | flushed while LSU busy; waiting for lsu_done to drop result
// -----------------------------------------------------------------------------
module load_store_request_queue #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CMD_WIDTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [CMD_WIDTH-1:0]      req_cmd,
   input  logic [DATA_WIDTH-1:0]     req_store_value,

   input  logic                      flush,

   output logic                      lsu_enable,
   output logic [ADDR_WIDTH-1:0]     lsu_addr,
   output logic [CMD_WIDTH-1:0]      lsu_cmd,
   output logic [DATA_WIDTH-1:0]     lsu_store_value,
   input  logic                      lsu_done,
   input  logic                      lsu_fault,
   input  logic [DATA_WIDTH-1:0]     lsu_result,

   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [DATA_WIDTH-1:0]     resp_result,
   output logic                      resp_fault,

   output logic [$clog2(DEPTH):0]    count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_INC = (PTR_W+1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_RESP  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
   logic                    lsu_enable_q, lsu_enable_d;
   logic                    resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]   resp_result_q, resp_result_d;
   logic                    resp_fault_q, resp_fault_d;

   logic [ADDR_WIDTH-1:0]   addr_mem_q  [DEPTH];
   logic [CMD_WIDTH-1:0]    cmd_mem_q   [DEPTH];
   logic [DATA_WIDTH-1:0]   store_mem_q [DEPTH];

   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    push;
   logic                    pop;
   logic                    clear_fifo;

   // Extra wrap bit distinguishes full from empty when the low bits match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign count      = wr_ptr_q - rd_ptr_q;

   // A held faulted response will wipe the queue on handshake, so nothing new
   // may slip in behind it.
   assign req_ready  = !fifo_full && !flush && (state_q != ST_DRAIN) &&
                       !(resp_valid_q && resp_fault_q);
   assign push       = req_valid && req_ready;

   assign lsu_enable      = lsu_enable_q;
   assign lsu_addr        = addr_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign lsu_cmd         = cmd_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign lsu_store_value = store_mem_q[rd_ptr_q[PTR_W-1:0]];

   assign resp_valid  = resp_valid_q;
   assign resp_result = resp_result_q;
   assign resp_fault  = resp_fault_q;

   always_comb begin
      state_d       = state_q;
      resp_valid_d  = resp_valid_q;
      resp_result_d = resp_result_q;
      resp_fault_d  = resp_fault_q;
      pop           = 1'b0;
      clear_fifo    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (flush) begin
               clear_fifo = 1'b1;
            end else if (!fifo_empty) begin
               state_d = ST_BUSY;
            end
         end

         ST_BUSY: begin
            if (flush) begin
               clear_fifo = 1'b1;
               state_d    = lsu_done ? ST_IDLE : ST_DRAIN;
            end else if (lsu_done) begin
               pop           = 1'b1;
               resp_valid_d  = 1'b1;
               resp_result_d = lsu_result;
               resp_fault_d  = lsu_fault;
               state_d       = ST_RESP;
            end
         end

         ST_RESP: begin
            if (flush) begin
               clear_fifo   = 1'b1;
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end else if (resp_ready) begin
               resp_valid_d = 1'b0;
               if (resp_fault_q) begin
                  clear_fifo = 1'b1;
                  state_d    = ST_IDLE;
               end else if (!fifo_empty) begin
                  state_d = ST_BUSY;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_DRAIN: begin
            if (lsu_done) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rd_ptr_d = pop  ? (rd_ptr_q + PTR_INC) : rd_ptr_q;
      wr_ptr_d = push ? (wr_ptr_q + PTR_INC) : wr_ptr_q;

      // Emptying by collapsing the write pointer onto the read pointer leaves
      // the in-flight head entry intact, so the LSU payload stays stable while
      // a killed access drains. push is never set together with clear_fifo.
      if (clear_fifo) begin
         wr_ptr_d = rd_ptr_q;
      end

      lsu_enable_d = (state_d == ST_BUSY) || (state_d == ST_DRAIN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         lsu_enable_q  <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         resp_fault_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         lsu_enable_q  <= lsu_enable_d;
         resp_valid_q  <= resp_valid_d;
         resp_result_q <= resp_result_d;
         resp_fault_q  <= resp_fault_d;
      end
   end

   // Payload storage needs no reset: an entry is only read after it is written.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem_q[wr_ptr_q[PTR_W-1:0]]  <= req_addr;
         cmd_mem_q[wr_ptr_q[PTR_W-1:0]]   <= req_cmd;
         store_mem_q[wr_ptr_q[PTR_W-1:0]] <= req_store_value;
      end
   end

endmodule

// File: tb/tb_load_store_request_queue.sv
// -----------------------------------------------------------------------------
// tb_load_store_request_queue
//
// Bench for load_store_request_queue. A behavioural model holds the queued
// requests in a SV queue plus a few flags (access in flight, access killed,
// response held) and is stepped once per clock; every cycle the DUT outputs
// are compared against it. Directed scenarios pin the model with literal
// expectations, then randomized traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_load_store_request_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int CW    = 4;

   logic           clk;
   logic           rst;
   logic           req_valid;
   logic           req_ready;
   logic [AW-1:0]  req_addr;
   logic [CW-1:0]  req_cmd;
   logic [DW-1:0]  req_store_value;
   logic           flush;
   logic           lsu_enable;
   logic [AW-1:0]  lsu_addr;
   logic [CW-1:0]  lsu_cmd;
   logic [DW-1:0]  lsu_store_value;
   logic           lsu_done;
   logic           lsu_fault;
   logic [DW-1:0]  lsu_result;
   logic           resp_valid;
   logic           resp_ready;
   logic [DW-1:0]  resp_result;
   logic           resp_fault;
   logic [2:0]     count;

   load_store_request_queue #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .CMD_WIDTH  (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_addr        (req_addr),
      .req_cmd         (req_cmd),
      .req_store_value (req_store_value),
      .flush           (flush),
      .lsu_enable      (lsu_enable),
      .lsu_addr        (lsu_addr),
      .lsu_cmd         (lsu_cmd),
      .lsu_store_value (lsu_store_value),
      .lsu_done        (lsu_done),
      .lsu_fault       (lsu_fault),
      .lsu_result      (lsu_result),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_result     (resp_result),
      .resp_fault      (resp_fault),
      .count           (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [AW-1:0] a;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          mq[$];       // requests accepted but not yet completed
   ent_t          m_kill_e;    // payload of an access killed by flush
   bit            m_inflight;  // LSU is being asked to perform an access
   bit            m_killed;    // that access has been flushed; result dropped
   bit            m_resp;      // a response is being offered
   logic [DW-1:0] m_res;
   bit            m_flt;

   task automatic model_reset();
      mq.delete();
      m_inflight = 0;
      m_killed   = 0;
      m_resp     = 0;
      m_res      = '0;
      m_flt      = 0;
   endtask

   function automatic bit m_ready();
      return (mq.size() < DEPTH) && !flush && !m_killed && !(m_resp && m_flt);
   endfunction

   task automatic model_step();
      int   pre;
      bit   do_push;
      ent_t e;
      pre     = mq.size();
      do_push = req_valid && m_ready();
      e.a = req_addr;
      e.c = req_cmd;
      e.d = req_store_value;
      if (m_killed) begin
         if (lsu_done) begin
            m_inflight = 0;
            m_killed   = 0;
         end
      end else if (m_inflight) begin
         if (flush) begin
            m_kill_e = mq[0];
            mq.delete();
            if (lsu_done) m_inflight = 0;
            else          m_killed   = 1;
         end else if (lsu_done) begin
            void'(mq.pop_front());
            m_inflight = 0;
            m_resp     = 1;
            m_res      = lsu_result;
            m_flt      = lsu_fault;
         end
      end else if (m_resp) begin
         if (flush) begin
            mq.delete();
            m_resp = 0;
         end else if (resp_ready) begin
            m_resp = 0;
            if (m_flt)        mq.delete();
            else if (pre > 0) m_inflight = 1;
         end
      end else begin
         if (flush)        mq.delete();
         else if (pre > 0) m_inflight = 1;
      end
      if (do_push) mq.push_back(e);
   endtask

   task automatic compare();
      ent_t h;
      check("req_ready", 64'(req_ready), 64'(m_ready()));
      check("lsu_enable", 64'(lsu_enable), 64'(m_inflight));
      if (m_inflight) begin
         h = m_killed ? m_kill_e : mq[0];
         check("lsu_addr", 64'(lsu_addr), 64'(h.a));
         check("lsu_cmd", 64'(lsu_cmd), 64'(h.c));
         check("lsu_store_value", 64'(lsu_store_value), 64'(h.d));
      end
      check("resp_valid", 64'(resp_valid), 64'(m_resp));
      if (m_resp) begin
         check("resp_result", 64'(resp_result), 64'(m_res));
         check("resp_fault", 64'(resp_fault), 64'(m_flt));
      end
      check("count", 64'(count), 64'(mq.size()));
   endtask

   // Inputs are set by the caller at negedge+1; this compares, advances the
   // model over the coming rising edge, and returns at the next negedge+1.
   task automatic tick();
      #1;
      compare();
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid       = 0;
      req_addr        = '0;
      req_cmd         = '0;
      req_store_value = '0;
      flush           = 0;
      lsu_done        = 0;
      lsu_fault       = 0;
      lsu_result      = '0;
      resp_ready      = 0;
   endtask

   task automatic wait_for_enable(input string name);
      int n;
      n = 0;
      while (!lsu_enable && n < 20) begin
         tick();
         n++;
      end
      check(name, 64'(lsu_enable), 64'h1);
   endtask

   task automatic push_req(input logic [AW-1:0] a, input logic [CW-1:0] c, input logic [DW-1:0] d);
      req_valid       = 1;
      req_addr        = a;
      req_cmd         = c;
      req_store_value = d;
      tick();
      req_valid = 0;
   endtask

   task automatic complete_one(input logic [DW-1:0] r, input bit f);
      wait_for_enable("complete_wait_enable");
      lsu_done   = 1;
      lsu_result = r;
      lsu_fault  = f;
      tick();
      lsu_done  = 0;
      lsu_fault = 0;
      check("complete_resp_valid", 64'(resp_valid), 64'h1);
      check("complete_resp_result", 64'(resp_result), 64'(r));
      resp_ready = 1;
      tick();
      resp_ready = 0;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 0;
      #1;
      check("rst_req_ready", 64'(req_ready), 64'h1);
      check("rst_lsu_enable", 64'(lsu_enable), 64'h0);
      check("rst_resp_valid", 64'(resp_valid), 64'h0);
      check("rst_resp_result", 64'(resp_result), 64'h0);
      check("rst_resp_fault", 64'(resp_fault), 64'h0);
      check("rst_count", 64'(count), 64'h0);

      // single load, done three cycles after the push
      push_req(32'h100, 4'h0, 32'h0);
      tick();
      check("r033_enable", 64'(lsu_enable), 64'h1);
      check("r033_addr", 64'(lsu_addr), 64'h100);
      tick();
      lsu_done   = 1;
      lsu_result = 32'hDEADBEEF;
      tick();
      lsu_done = 0;
      check("r033_resp_valid", 64'(resp_valid), 64'h1);
      check("r033_resp_result", 64'(resp_result), 64'hDEADBEEF);
      check("r033_resp_fault", 64'(resp_fault), 64'h0);
      check("r033_enable_off", 64'(lsu_enable), 64'h0);
      resp_ready = 1;
      tick();
      resp_ready = 0;
      check("r033_resp_gone", 64'(resp_valid), 64'h0);
      check("r033_count", 64'(count), 64'h0);

      // fill to DEPTH with the LSU stalled, then drain in order
      for (int i = 0; i < 4; i++)
         push_req(32'h200 + 32'(16*i), 4'(i), 32'h1000 + 32'(i));
      check("r034_count_full", 64'(count), 64'h4);
      check("r034_not_ready", 64'(req_ready), 64'h0);
      req_valid = 1;
      req_addr  = 32'hBAD;
      tick();
      req_valid = 0;
      check("r034_no_overflow", 64'(count), 64'h4);
      for (int i = 0; i < 4; i++) begin
         wait_for_enable("r034_wait");
         check("r034_order_addr", 64'(lsu_addr), 64'h200 + 64'(16*i));
         check("r034_order_data", 64'(lsu_store_value), 64'h1000 + 64'(i));
         complete_one(32'hA000 + 32'(i), 0);
      end
      check("r034_empty", 64'(count), 64'h0);

      // second of three faults: third is discarded and never issued
      for (int i = 0; i < 3; i++)
         push_req(32'h300 + 32'(i), 4'h1, 32'h0);
      complete_one(32'h1, 0);
      wait_for_enable("r035_wait");
      check("r035_second_addr", 64'(lsu_addr), 64'h301);
      lsu_done   = 1;
      lsu_fault  = 1;
      lsu_result = 32'h2;
      tick();
      lsu_done  = 0;
      lsu_fault = 0;
      check("r035_fault", 64'(resp_fault), 64'h1);
      check("r035_ready_blocked", 64'(req_ready), 64'h0);
      resp_ready = 1;
      tick();
      resp_ready = 0;
      check("r035_count", 64'(count), 64'h0);
      for (int i = 0; i < 5; i++) tick();
      check("r035_no_issue", 64'(lsu_enable), 64'h0);

      // flush while BUSY with two behind the head
      for (int i = 0; i < 3; i++)
         push_req(32'h400 + 32'(i), 4'h2, 32'h0);
      flush = 1;
      tick();
      flush = 0;
      check("r036_count", 64'(count), 64'h0);
      check("r036_enable_held", 64'(lsu_enable), 64'h1);
      check("r036_drain_addr", 64'(lsu_addr), 64'h400);
      tick();
      tick();
      check("r036_still_enabled", 64'(lsu_enable), 64'h1);
      check("r036_no_resp", 64'(resp_valid), 64'h0);
      check("r036_drain_blocks", 64'(req_ready), 64'h0);
      lsu_done   = 1;
      lsu_result = 32'h4444;
      tick();
      lsu_done = 0;
      check("r036_enable_off", 64'(lsu_enable), 64'h0);
      check("r036_no_resp_after", 64'(resp_valid), 64'h0);
      tick();
      check("r036_idle_ready", 64'(req_ready), 64'h1);

      // response back-pressure: payload holds, pushes continue until full
      push_req(32'h500, 4'h3, 32'h0);
      wait_for_enable("r037_wait");
      lsu_done   = 1;
      lsu_result = 32'h5555;
      tick();
      lsu_done = 0;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1;
         req_addr  = 32'h600 + 32'(i);
         tick();
         check("r037_result_stable", 64'(resp_result), 64'h5555);
         check("r037_valid_stable", 64'(resp_valid), 64'h1);
         check("r037_lsu_idle", 64'(lsu_enable), 64'h0);
      end
      req_valid = 0;
      check("r037_count_full", 64'(count), 64'h4);
      resp_ready = 1;
      tick();
      resp_ready = 0;
      for (int i = 0; i < 4; i++) begin
         wait_for_enable("r037_drain_wait");
         check("r037_drain_addr", 64'(lsu_addr), 64'h600 + 64'(i));
         complete_one(32'h7700 + 32'(i), 0);
      end

      // asynchronous reset while BUSY
      push_req(32'h800, 4'h4, 32'h0);
      push_req(32'h801, 4'h4, 32'h0);
      wait_for_enable("r038_wait");
      #3;
      rst = 1;
      #1;
      check("r038_lsu_enable", 64'(lsu_enable), 64'h0);
      check("r038_resp_valid", 64'(resp_valid), 64'h0);
      check("r038_resp_result", 64'(resp_result), 64'h0);
      check("r038_resp_fault", 64'(resp_fault), 64'h0);
      check("r038_count", 64'(count), 64'h0);
      model_reset();
      @(negedge clk);
      rst = 0;
      #1;
      check("r038_ready_after", 64'(req_ready), 64'h1);
      tick();
      check("r038_no_resp", 64'(resp_valid), 64'h0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         req_valid       = 1'($urandom_range(0, 1));
         req_addr        = $urandom;
         req_cmd         = 4'($urandom);
         req_store_value = $urandom;
         flush           = ($urandom_range(0, 24) == 0);
         lsu_done        = ($urandom_range(0, 2) == 0);
         lsu_fault       = ($urandom_range(0, 6) == 0);
         lsu_result      = $urandom;
         resp_ready      = 1'($urandom_range(0, 1));
         tick();
      end
      idle_inputs();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
